// File: rtl/updn_sweep_ctrl.sv
// Triangle-sweep controller for an external loadable up/down counter (lo -> hi -> lo).
// Define SWEEP_DWELL_EN to add endpoint dwell states driven by the dwell input.
module updn_sweep_ctrl #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [width-1:0] lo,
    input  logic [width-1:0] hi,
    input  logic [7:0]       dwell,
    input  logic [7:0]       n_sweeps,
    input  logic [width-1:0] count_in,
    output logic [width-1:0] data,
    output logic             load,
    output logic             cen,
    output logic             up_dn,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       sweeps
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_UP       = 3'd2,
        S_DOWN     = 3'd3,
`ifdef SWEEP_DWELL_EN
        S_DWELL_HI = 3'd5,
        S_DWELL_LO = 3'd6,
`endif
        S_HOLD     = 3'd4
    } state_t;

    localparam logic [width:0] one_w = {{width{1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [width-1:0] lo_r;
    logic [width-1:0] hi_r;
    logic [7:0]       n_sweeps_r;
    logic [width-1:0] data_r;
    logic             err_r;
    logic             done_r;
    logic [7:0]       sweeps_r;
    logic             accept_s;
    logic             bounds_ok_s;
    logic             at_top_s;
    logic             at_bot_s;
    logic [7:0]       sweeps_inc_s;
    logic             limit_s;

    // Endpoint compares are done one bit wider so hi at full scale cannot wrap.
    assign accept_s     = (state_r == S_IDLE) && start && !stop;
    assign bounds_ok_s  = (lo <= hi);
    assign at_top_s     = (({1'b0, count_in} + one_w) == {1'b0, hi_r});
    assign at_bot_s     = ({1'b0, count_in} == ({1'b0, lo_r} + one_w));
    assign sweeps_inc_s = (sweeps_r == 8'd255) ? 8'd255 : (sweeps_r + 8'd1);
    assign limit_s      = (n_sweeps_r != 8'd0) && (sweeps_inc_s == n_sweeps_r);

`ifdef SWEEP_DWELL_EN
    logic [7:0] dwell_r;
    logic [7:0] dwell_cnt_r;
    logic       dwell_end_s;

    assign dwell_end_s = (dwell_cnt_r == (dwell_r - 8'd1));

    // Dwell cycle counter: runs while parked in a dwell state, clears otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_cnt_r <= 8'd0;
        end else if (((state_r == S_DWELL_HI) || (state_r == S_DWELL_LO)) && (state_s == state_r)) begin
            dwell_cnt_r <= dwell_cnt_r + 8'd1;
        end else begin
            dwell_cnt_r <= 8'd0;
        end
    end
`else
    logic unused_dwell_s;
    assign unused_dwell_s = ^dwell;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; stop overrides every other transition outside IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && bounds_ok_s) state_s = S_LOAD;
                else                         state_s = S_IDLE;
            end
            S_LOAD: begin
                if (stop)                 state_s = S_IDLE;
                else if (lo_r == hi_r)    state_s = S_HOLD;
                else                      state_s = S_UP;
            end
            S_UP: begin
                if (stop)                 state_s = S_IDLE;
`ifdef SWEEP_DWELL_EN
                else if (at_top_s)        state_s = (dwell_r != 8'd0) ? S_DWELL_HI : S_DOWN;
`else
                else if (at_top_s)        state_s = S_DOWN;
`endif
                else                      state_s = S_UP;
            end
            S_DOWN: begin
                if (stop)                 state_s = S_IDLE;
                else if (at_bot_s && limit_s) state_s = S_IDLE;
`ifdef SWEEP_DWELL_EN
                else if (at_bot_s)        state_s = (dwell_r != 8'd0) ? S_DWELL_LO : S_UP;
`else
                else if (at_bot_s)        state_s = S_UP;
`endif
                else                      state_s = S_DOWN;
            end
`ifdef SWEEP_DWELL_EN
            S_DWELL_HI: begin
                if (stop)                 state_s = S_IDLE;
                else if (dwell_end_s)     state_s = S_DOWN;
                else                      state_s = S_DWELL_HI;
            end
            S_DWELL_LO: begin
                if (stop)                 state_s = S_IDLE;
                else if (dwell_end_s)     state_s = S_UP;
                else                      state_s = S_DWELL_LO;
            end
`endif
            S_HOLD: begin
                if (stop)                 state_s = S_IDLE;
                else                      state_s = S_HOLD;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Counter control decoded from the state register.
    always_comb begin
        load  = 1'b1;
        cen   = 1'b0;
        up_dn = 1'b1;
        busy  = 1'b1;
        case (state_r)
            S_IDLE:  busy = 1'b0;
            S_LOAD:  load = 1'b0;
            S_UP:    cen  = 1'b1;
            S_DOWN: begin
                cen   = 1'b1;
                up_dn = 1'b0;
            end
            S_HOLD:  busy = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Bound/limit capture on start in IDLE; data only moves on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_r       <= '0;
            hi_r       <= '0;
            n_sweeps_r <= 8'd0;
            data_r     <= '0;
`ifdef SWEEP_DWELL_EN
            dwell_r    <= 8'd0;
`endif
        end else if (accept_s) begin
            lo_r       <= lo;
            hi_r       <= hi;
            n_sweeps_r <= n_sweeps;
`ifdef SWEEP_DWELL_EN
            dwell_r    <= dwell;
`endif
            if (bounds_ok_s) data_r <= lo;
        end
    end

    // Status flags: sticky bound error, completion pulse, period counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r    <= 1'b0;
            done_r   <= 1'b0;
            sweeps_r <= 8'd0;
        end else begin
            done_r <= (state_r == S_DOWN) && !stop && at_bot_s && limit_s;
            if (accept_s) begin
                err_r <= !bounds_ok_s;
                if (bounds_ok_s) sweeps_r <= 8'd0;
            end else if ((state_r == S_DOWN) && at_bot_s) begin
                sweeps_r <= sweeps_inc_s;
            end
        end
    end

    assign data   = data_r;
    assign err    = err_r;
    assign done   = done_r;
    assign sweeps = sweeps_r;

endmodule
